// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared branch-control constants, FSM encoding and compare helpers
// Contents: funct3 codes, Branch one-hot bit indices, PC-unit state enum,
//           br_funct3() maps a Branch bit index to its funct3,
//           br_cond() evaluates one branch condition.
package rv32_ctrl_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;
    localparam int BR_W    = 6;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic logic [2:0] br_funct3(input int idx);
        case (idx)
            BR_BEQ:  return FUNCT3_BEQ;
            BR_BNE:  return FUNCT3_BNE;
            BR_BLT:  return FUNCT3_BLT;
            BR_BGE:  return FUNCT3_BGE;
            BR_BLTU: return FUNCT3_BLTU;
            BR_BGEU: return FUNCT3_BGEU;
            default: return FUNCT3_BEQ;
        endcase
    endfunction

    function automatic logic br_cond(input logic [2:0] funct3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        case (funct3)
            FUNCT3_BEQ:  return a == b;
            FUNCT3_BNE:  return a != b;
            FUNCT3_BLT:  return $signed(a) <  $signed(b);
            FUNCT3_BGE:  return $signed(a) >= $signed(b);
            FUNCT3_BLTU: return a <  b;
            FUNCT3_BGEU: return a >= b;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition resolver
// Ports: RD1/RD2 operands, Branch one-hot type in;
//        CondTrue (selected condition holds), MultiHot (illegal multi-bit Branch) out.
module branch_cmp
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0]     RD1,
    input  logic [31:0]     RD2,
    input  logic [BR_W-1:0] Branch,
    output logic            CondTrue,
    output logic            MultiHot
);

    logic hit;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < BR_W; i++) begin
            hit = hit | (Branch[i] & br_cond(br_funct3(i), RD1, RD2));
        end
        // x & (x-1) clears the lowest set bit; anything left means two or more bits.
        MultiHot = (Branch & (Branch - 1'b1)) != '0;
        CondTrue = hit & ~MultiHot;
    end

endmodule

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - branch resolution, next-PC, PC register and post-redirect flush sequencer
// Ports: clk, rst (sync active-low), en (0 = stall); Branch/Jump/JumpReg controls,
//        RD1/RD2/ImmExt operands; PC (registered), PCPlus4/PCTarget/Taken (comb),
//        Flush/Misalign/BrErr (registered).
// Build option BRANCH_PC_STATS_EN adds BrCount/TakenCount saturating counters.
module branch_pc_unit
    import rv32_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [BR_W-1:0] Branch,
    input  logic            Jump,
    input  logic            JumpReg,
    input  logic [31:0]     RD1,
    input  logic [31:0]     RD2,
    input  logic [31:0]     ImmExt,
    output logic [31:0]     PC,
    output logic [31:0]     PCPlus4,
    output logic [31:0]     PCTarget,
    output logic            Taken,
    output logic            Flush,
    output logic            Misalign,
    output logic            BrErr
`ifdef BRANCH_PC_STATS_EN
    ,
    output logic [31:0]     BrCount,
    output logic [31:0]     TakenCount
`endif
);

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    logic [31:0] pc_q, pc_d;
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;
    logic        brerr_q, brerr_d;

    logic        cond_true, multi_hot;
    logic        redirect_req, misalign_hit;
    logic [31:0] jalr_sum;

    branch_cmp u_cmp (
        .RD1      (RD1),
        .RD2      (RD2),
        .Branch   (Branch),
        .CondTrue (cond_true),
        .MultiHot (multi_hot)
    );

    // Output / datapath logic
    always_comb begin
        PCPlus4  = pc_q + 32'd4;
        jalr_sum = RD1 + ImmExt;
        if (Jump && JumpReg) begin
            PCTarget = jalr_sum & ~32'd1;
        end else begin
            PCTarget = pc_q + ImmExt;
        end
        // In FLUSH the instruction at this PC is being squashed, so its controls are ignored.
        redirect_req = (state_q == ST_RUN) && (Jump || cond_true);
        Taken        = redirect_req && !PCTarget[1];
        misalign_hit = redirect_req && PCTarget[1];
    end

    // Next-state logic
    always_comb begin
        pc_d       = pc_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = flush_q;
        brerr_d    = brerr_q;
        misalign_d = en && misalign_hit;
        if (en) begin
            case (state_q)
                ST_RUN: begin
                    brerr_d = brerr_q | multi_hot;
                    if (Taken) begin
                        pc_d    = PCTarget;
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_INIT;
                        flush_d = 1'b1;
                    end else begin
                        pc_d = PCPlus4;
                    end
                end
                ST_FLUSH: begin
                    pc_d = PCPlus4;
                    if (cnt_q == 3'd0) begin
                        state_d = ST_RUN;
                        flush_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            state_q    <= ST_RUN;
            cnt_q      <= 3'd0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
            brerr_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
            brerr_q    <= brerr_d;
        end
    end

    assign PC       = pc_q;
    assign Flush    = flush_q;
    assign Misalign = misalign_q;
    assign BrErr    = brerr_q;

`ifdef BRANCH_PC_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] taken_count_q, taken_count_d;
    logic        single_br;

    always_comb begin
        single_br     = en && (state_q == ST_RUN) && (Branch != '0) && !multi_hot;
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (single_br && (br_count_q != 32'hFFFF_FFFF)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (single_br && Taken && (taken_count_q != 32'hFFFF_FFFF)) begin
            taken_count_d = taken_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            br_count_q    <= 32'd0;
            taken_count_q <= 32'd0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign BrCount    = br_count_q;
    assign TakenCount = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - directed plus randomized check of branch_pc_unit against a behavioural model
module tb_branch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam int          FC     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [5:0]  Branch = '0;
    logic        Jump = 1'b0;
    logic        JumpReg = 1'b0;
    logic [31:0] RD1 = '0, RD2 = '0, ImmExt = '0;
    logic [31:0] PC, PCPlus4, PCTarget;
    logic        Taken, Flush, Misalign, BrErr;
`ifdef BRANCH_PC_STATS_EN
    logic [31:0] BrCount, TakenCount;
`endif

    branch_pc_unit #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .en(en), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
        .RD1(RD1), .RD2(RD2), .ImmExt(ImmExt), .PC(PC), .PCPlus4(PCPlus4),
        .PCTarget(PCTarget), .Taken(Taken), .Flush(Flush), .Misalign(Misalign), .BrErr(BrErr)
`ifdef BRANCH_PC_STATS_EN
        , .BrCount(BrCount), .TakenCount(TakenCount)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Behavioural model: flush_left counts enabled flush cycles still owed.
    logic [31:0] m_pc;
    int          m_flush_left;
    bit          m_misalign, m_brerr;
    logic [31:0] m_brcount, m_takencount;
    logic [31:0] m_tgt;
    bit          m_req, m_taken;
    bit          obs_taken;
    logic [31:0] obs_tgt;

    function automatic bit m_cond(input logic [5:0] br, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (br)
            6'b000001: return a == b;
            6'b000010: return a != b;
            6'b000100: return sa < sb;
            6'b001000: return sa >= sb;
            6'b010000: return {1'b0, a} < {1'b0, b};
            6'b100000: return {1'b0, a} >= {1'b0, b};
            default:   return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_flush_left = 0; m_misalign = 0; m_brerr = 0;
        m_brcount = 0; m_takencount = 0;
    endtask

    task automatic model_comb();
        if (Jump && JumpReg) m_tgt = (RD1 + ImmExt) & 32'hFFFF_FFFE;
        else                 m_tgt = m_pc + ImmExt;
        m_req   = (m_flush_left == 0) && (Jump || m_cond(Branch, RD1, RD2));
        m_taken = m_req && (m_tgt[1] == 1'b0);
    endtask

    task automatic model_edge();
        if (!en) begin
            m_misalign = 0;
        end else if (m_flush_left == 0) begin
            if ($countones(Branch) > 1) m_brerr = 1;
            m_misalign = m_req && m_tgt[1];
            if ($countones(Branch) == 1) begin
                if (m_brcount != 32'hFFFF_FFFF) m_brcount++;
                if (m_taken && m_takencount != 32'hFFFF_FFFF) m_takencount++;
            end
            if (m_taken) begin
                m_pc = m_tgt;
                m_flush_left = FC;
            end else begin
                m_pc = m_pc + 4;
            end
        end else begin
            m_pc = m_pc + 4;
            m_flush_left--;
            m_misalign = 0;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc"}, PC, m_pc);
        check({tag, ".flush"}, {31'd0, Flush}, {31'd0, m_flush_left > 0});
        check({tag, ".misalign"}, {31'd0, Misalign}, {31'd0, m_misalign});
        check({tag, ".brerr"}, {31'd0, BrErr}, {31'd0, m_brerr});
`ifdef BRANCH_PC_STATS_EN
        check({tag, ".brcount"}, BrCount, m_brcount);
        check({tag, ".takencount"}, TakenCount, m_takencount);
`endif
    endtask

    // Called right after a falling edge; returns at the next falling edge.
    task automatic cycle(input string tag, input bit e, input logic [5:0] br, input bit j,
                         input bit jr, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm);
        en = e; Branch = br; Jump = j; JumpReg = jr; RD1 = a; RD2 = b; ImmExt = imm;
        #1;
        model_comb();
        obs_taken = Taken;
        obs_tgt   = PCTarget;
        check({tag, ".taken"}, {31'd0, Taken}, {31'd0, m_taken});
        check({tag, ".target"}, PCTarget, m_tgt);
        check({tag, ".pcplus4"}, PCPlus4, m_pc + 4);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1, 6'b0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst = 0; en = 1; Branch = 0; Jump = 0; JumpReg = 0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check_regs(tag);
        rst = 1;
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");
        check("reset_pc", PC, 32'h100);

        idle("seq0"); check("seq_pc0", PC, 32'h104);
        idle("seq1"); check("seq_pc1", PC, 32'h108);
        idle("seq2"); check("seq_pc2", PC, 32'h10C);

        // JAL to 0x1F8, two flush bubbles bring PC to 0x200
        cycle("jal", 1, 6'b0, 1, 0, 32'h0, 32'h0, 32'hEC);
        check("jal_pc", PC, 32'h1F8);
        idle("jfl0"); idle("jfl1");
        check("at_200", PC, 32'h200);

        cycle("blt", 1, 6'b000100, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0);
        check("blt_taken", {31'd0, obs_taken}, 32'd1);
        check("blt_pc", PC, 32'h1F0);
        check("blt_flush", {31'd0, Flush}, 32'd1);
        idle("bfl0"); check("bfl0_pc", PC, 32'h1F4); check("bfl0_flush", {31'd0, Flush}, 32'd1);
        idle("bfl1"); check("bfl1_pc", PC, 32'h1F8); check("bfl1_flush", {31'd0, Flush}, 32'd0);

        cycle("bltu", 1, 6'b010000, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0);
        check("bltu_taken", {31'd0, obs_taken}, 32'd0);
        check("bltu_pc", PC, 32'h1FC);

        cycle("jalr_mis", 1, 6'b0, 1, 1, 32'h1003, 32'h0, 32'h0);
        check("jalr_target", obs_tgt, 32'h1002);
        check("jalr_taken", {31'd0, obs_taken}, 32'd0);
        check("jalr_misalign", {31'd0, Misalign}, 32'd1);
        check("jalr_pc", PC, 32'h200);
        idle("mis_clr"); check("misalign_pulse", {31'd0, Misalign}, 32'd0);

        // redirect then stall mid-flush
        cycle("jal2", 1, 6'b0, 1, 0, 32'h0, 32'h0, 32'h40);
        check("jal2_pc", PC, 32'h244);
        for (int k = 0; k < 3; k++) begin
            cycle("stall", 0, 6'b0, 0, 0, 32'h0, 32'h0, 32'h0);
            check("stall_pc", PC, 32'h244);
            check("stall_flush", {31'd0, Flush}, 32'd1);
        end
        idle("sfl0"); check("sfl0_flush", {31'd0, Flush}, 32'd1);
        idle("sfl1"); check("sfl1_flush", {31'd0, Flush}, 32'd0);

        cycle("jal3", 1, 6'b0, 1, 0, 32'h0, 32'h0, 32'h80);
        check("jal3_flush", {31'd0, Flush}, 32'd1);
        do_reset("midflush_rst");
        check("midrst_pc", PC, 32'h100);
        check("midrst_flush", {31'd0, Flush}, 32'd0);

        cycle("multihot", 1, 6'b000011, 0, 0, 32'h55, 32'h55, 32'h20);
        check("multihot_taken", {31'd0, obs_taken}, 32'd0);
        check("multihot_brerr", {31'd0, BrErr}, 32'd1);
        idle("sticky0"); idle("sticky1");
        check("brerr_sticky", {31'd0, BrErr}, 32'd1);
        do_reset("brerr_rst");
        check("brerr_cleared", {31'd0, BrErr}, 32'd0);

        for (int n = 0; n < 400; n++) begin
            logic [5:0]  br;
            logic [31:0] a, b, imm;
            int          sel, off;
            bit          e, j, jr;
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_rst");
            end else begin
                sel = int'($urandom_range(0, 9));
                if (sel < 4)       br = 6'b0;
                else if (sel < 9)  br = 6'b1 << $urandom_range(0, 5);
                else               br = 6'($urandom);
                j   = ($urandom_range(0, 3) == 0);
                jr  = $urandom_range(0, 1) != 0;
                e   = ($urandom_range(0, 7) != 0);
                a   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
                b   = ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) != 0) ? $urandom
                                                         : 32'($urandom_range(0, 15)) - 32'd8);
                off = int'($urandom_range(0, 255)) - 128;
                imm = 32'(off * 2);
                cycle("rnd", e, br, j, jr, a, b, imm);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Consumer end of the main decoder's control interface.
- Takes the one-hot Branch[5:0], Jump and JumpReg controls plus register operands and the extended immediate.
- Resolves branch conditions, computes the next-PC, and owns the architectural PC register.
- Sequences a fixed-length flush window after every taken redirect, for the pipelined RV32I core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 2, bubbles requested after each taken redirect; legal range 1..7.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  advance enable; 0 = stall, all state held.
- Branch  input  6  one-hot branch type: bit0 BEQ, bit1 BNE, bit2 BLT, bit3 BGE, bit4 BLTU, bit5 BGEU.
- Jump  input  1  unconditional jump (JAL/JALR).
- JumpReg  input  1  with Jump: JALR target; ignored when Jump=0.
- RD1  input  32  rs1 operand.
- RD2  input  32  rs2 operand.
- ImmExt  input  32  sign-extended immediate.
- PC  output  32  registered current PC.
- PCPlus4  output  32  PC+4, combinational.
- PCTarget  output  32  resolved target, combinational.
- Taken  output  1  redirect decision this cycle, combinational.
- Flush  output  1  registered; high while the flush window is active.
- Misalign  output  1  registered one-cycle pulse on a misaligned target.
- BrErr  output  1  registered sticky flag for illegal multi-hot Branch.

Behaviour:
- Reset (rst=0 at a rising edge), from any state including mid-flush:
  - PC=RESET_PC; Flush=0; Misalign=0; BrErr=0.
  - State=RUN; flush counter=0.
- Condition evaluation:
  - BEQ: RD1==RD2. BNE: RD1!=RD2.
  - BLT/BGE: signed compare, RD1<RD2 / RD1>=RD2.
  - BLTU/BGEU: unsigned compare.
- CondTrue is the OR of (Branch[i] & cond[i]).
- Multi-hot Branch (more than one bit set): CondTrue forced to 0; BrErr set on the next edge if en=1 and state=RUN. BrErr clears only on reset.
- Target arithmetic, modulo 2^32, wrap-around permitted with no flag:
  - Jump & JumpReg: PCTarget = (RD1+ImmExt) with bit0 cleared.
  - Otherwise: PCTarget = PC+ImmExt.
- Taken = state==RUN & (Jump | CondTrue) & (PCTarget[1]==0).
- Misaligned target: if state==RUN and (Jump | CondTrue) and PCTarget[1]=1:
  - Taken=0; PC advances by 4.
  - Misalign pulses for one cycle on the next edge.
- State RUN, en=1:
  - Taken=1: PC<=PCTarget; Flush<=1; counter<=FLUSH_CYCLES-1; state<=FLUSH.
  - Taken=0: PC<=PC+4.
- State FLUSH, en=1:
  - Branch, Jump and JumpReg are ignored (squashed instruction); PC<=PC+4.
  - counter==0: state<=RUN, Flush<=0. Otherwise counter decrements and Flush stays 1.
- en=0, any state: PC, state, counter, Flush and BrErr are held; Misalign<=0.
- Latency: the redirect is visible on PC one cycle after the Taken cycle. Flush is high for exactly FLUSH_CYCLES enabled cycles.
- Simultaneous Branch and Jump: Jump dominates the target; Taken if the target is aligned.

Optional Feature:
- Macro: BRANCH_PC_STATS_EN.
- Defined: adds output ports BrCount[31:0] and TakenCount[31:0], both reset to 0.
  - BrCount increments on each enabled RUN cycle with exactly one Branch bit set.
  - TakenCount increments when such a cycle is Taken.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: no ports, no counter logic.

Decomposition:
- Package rv32_ctrl_pkg holds:
  - func3 constants BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - Branch bit indices BR_BEQ..BR_BGEU.
  - State encodings ST_RUN=1'b0, ST_FLUSH=1'b1.
- One sub-module: branch_cmp, purely combinational. Inputs RD1, RD2, Branch; outputs CondTrue and MultiHot.

Test Plan:
- Reset with RESET_PC=32'h100, then 3 cycles en=1, no controls -> PC 0x100, 0x104, 0x108, 0x10C; Flush=0.
- PC=0x200, Branch=6'b000100 (BLT), RD1=32'hFFFF_FFFF, RD2=1, ImmExt=-16 -> Taken=1; next PC=0x1F0; Flush=1 for exactly 2 cycles; PC then 0x1F4, 0x1F8.
- Same operands with Branch=6'b010000 (BLTU) -> Taken=0; next PC=0x204.
- Jump=1, JumpReg=1, RD1=0x1003, ImmExt=0 -> PCTarget=0x1002; Misalign pulses once; PC advances by 4.
- Taken redirect, then en=0 for 3 cycles mid-flush -> PC and Flush frozen; flush completes after 2 further enabled cycles. rst=0 mid-flush -> PC=RESET_PC, Flush=0 on the next edge.
- Branch=6'b000011 with RD1==RD2 -> Taken=0; BrErr=1 and stays 1 until reset.
